// File: rtl/seq_mult_if.sv
// Start/done handshake and operand/result bus for the shift-and-add multiplier.
interface seq_mult_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult.sv
// Multi-cycle unsigned shift-and-add multiplier. One 2*WIDTH adder is reused
// for WIDTH cycles; the product register only updates on entry to DONE.
module seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  seq_mult_if.slave s
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  acc, mcand, acc_sum, prod_q;
  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]  count;
  logic           accept, last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start is only looked at in IDLE so it cannot queue.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (s.start) begin
        state_nxt = CALC;
        accept    = 1'b1;
      end
      CALC: begin
        last = (count == CW'(WIDTH - 1));
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conditional add of the shifted multiplicand; sum fits in PW bits.
  assign acc_sum = acc + (mplr[0] ? mcand : '0);

  // Datapath: capture operands on accept, shift/add each CALC cycle, and
  // publish the final sum (including the last add) as the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      count  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, s.a};
      mplr   <= s.b;
      count  <= '0;
    end else if (state == CALC) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplr   <= mplr >> 1;
      count  <= count + 1'b1;
      if (last) prod_q <= acc_sum;
    end
  end

  // Outputs are decoded from registers only.
  assign s.busy    = (state != IDLE);
  assign s.done    = (state == DONE);
  assign s.product = prod_q;
endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult (WIDTH=4): a timeline model of the handshake
// is compared against the outputs every cycle, and directed scenarios pin
// products, latency and done counts with hand-computed values.
module tb_seq_mult;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   npass = 0;
  int   ntot  = 0;
  bit   chk_en = 1'b0;

  seq_mult_if #(.WIDTH(W)) bus ();
  seq_mult #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model: an accepted request keeps the unit busy for W+1 cycles, the last
  // of which is the done cycle; the product becomes a*b when done begins.
  int         m_left = 0;
  logic [7:0] m_res  = '0;
  logic [7:0] m_prod = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_prod = '0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_res  = 8'(bus.a) * 8'(bus.b);
        m_left = W + 1;
      end
    end else begin
      m_left--;
      if (m_left == 1) m_prod = m_res;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",    32'(bus.busy),    32'(m_left != 0));
      chk("done",    32'(bus.done),    32'(m_left == 1));
      chk("product", 32'(bus.product), 32'(m_prod));
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] lit, input string nm);
    int lat = 0;
    bit seen = 1'b0;
    logic [7:0] p = '0;
    bus.a = av; bus.b = bv; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      bus.a = 4'($urandom); bus.b = 4'($urandom);
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; lat = i; p = bus.product; end
      if (!seen) step();
    end
    chk({nm, " done seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"},   32'(lat),  32'd5);
    chk({nm, " product"},   32'(p),    32'(lit));
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nd, first, lastd;
    logic [7:0] p;

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy",    32'(bus.busy),    32'd0);
    chk("reset done",    32'(bus.done),    32'd0);
    chk("reset product", 32'(bus.product), 32'd0);
    step();

    run_op(4'd3,  4'd4, 8'd12,  "3x4");
    run_op(4'd15, 4'd15, 8'hE1, "15x15");
    run_op(4'd0,  4'd9, 8'd0,   "0x9");
    run_op(4'd11, 4'd0, 8'd0,   "11x0");

    // Second start while busy must be ignored; operands wiggle every cycle.
    nd = 0; first = -1; p = '0;
    for (int i = 0; i < 12; i++) begin
      bus.start = (i == 0 || i == 2);
      if (i == 0)      begin bus.a = 4'd5; bus.b = 4'd6; end
      else if (i == 2) begin bus.a = 4'd7; bus.b = 4'd7; end
      else             begin bus.a = 4'($urandom); bus.b = 4'($urandom); end
      @(negedge clk);
      if (bus.done) begin nd++; if (first < 0) first = i; p = bus.product; end
      step();
    end
    bus.start = 1'b0;
    chk("ignore-start dones",   32'(nd),    32'd1);
    chk("ignore-start done at", 32'(first), 32'd5);
    chk("ignore-start product", 32'(p),     32'd30);

    // Reset mid-operation abandons it with no done pulse.
    nd = 0;
    for (int i = 0; i < 13; i++) begin
      bus.start = (i == 0);
      bus.a = 4'd9; bus.b = 4'd9;
      rst = (i == 3);
      @(negedge clk);
      if (i == 4) begin
        chk("midreset busy",    32'(bus.busy),    32'd0);
        chk("midreset done",    32'(bus.done),    32'd0);
        chk("midreset product", 32'(bus.product), 32'd0);
      end
      if (i >= 4 && bus.done) nd++;
      step();
    end
    rst = 1'b0; bus.start = 1'b0;
    chk("midreset dones", 32'(nd), 32'd0);

    // rst and start together: reset wins.
    rst = 1'b1; bus.start = 1'b1; bus.a = 4'd3; bus.b = 4'd3;
    step();
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("rst+start busy", 32'(bus.busy), 32'd0);
    step();

    // start held high: one operation every W+2 cycles.
    nd = 0; first = -1; lastd = -1;
    for (int i = 0; i < 20; i++) begin
      bus.start = 1'b1; bus.a = 4'd2; bus.b = 4'd3;
      @(negedge clk);
      if (bus.done) begin
        nd++;
        if (first < 0) first = i;
        lastd = i;
        chk("held product", 32'(bus.product), 32'd6);
      end
      step();
    end
    bus.start = 1'b0;
    repeat (8) step();
    chk("held dones",      32'(nd),    32'd3);
    chk("held first done", 32'(first), 32'd5);
    chk("held last done",  32'(lastd), 32'd17);

    // Exhaustive pairs.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(4'(x), 4'(y), 8'(x * y), "exh");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
